power_rail_sequencer: RTL and testbench

POWER_RAIL_SEQUENCER -- requirements
Module: power_rail_sequencer

---
 rtl/power_rail_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_power_rail_sequencer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/power_rail_sequencer.sv
// -----------------------------------------------------------------------------
// power_rail_sequencer
//
// Brings two regulator rails up in order and takes them down in reverse.
// Rail 0 is enabled first. Once its power-good is seen, the block waits
// SEQ_DLY cycles and then enables rail 1. Power-down releases rail 1 first
// and holds rail 0 on for SEQ_DLY cycles. Power-good timeouts and power-good
// loss latch a FAULT. FAULT is left only on a fault-clear edge while the
// power-on request is low.
//
// Parameters
//   SEQ_DLY : rail-0-good to rail-1-enable delay, and the power-down hold (clk cycles)
//   PG_TMO  : cycles allowed for a rail to report power-good after enable
//   CNT_W   : width of the shared sequencing counter
//
// Ports
//   clk        : system clock
//   reset_n    : asynchronous active-low reset
//   req[1:0]   : bit0 = power-on request (level), bit1 = fault clear (rising edge)
//   pgood[1:0] : asynchronous regulator power-good, one bit per rail
//   rail_en    : registered regulator enables (bit0 = rail 0, bit1 = rail 1)
//   power_ok   : high only while both rails are up (state ON)
//   fault      : high only in state FAULT
//   fault_code : 00 none, 01 rail-0 fail, 10 rail-1 timeout, 11 power-good lost in ON
// -----------------------------------------------------------------------------
module power_rail_sequencer #(
    parameter int SEQ_DLY = 1000,
    parameter int PG_TMO  = 100000,
    parameter int CNT_W   = 20
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic [1:0] pgood,
    output logic [1:0] rail_en,
    output logic       power_ok,
    output logic       fault,
    output logic [1:0] fault_code
);

    typedef enum logic [2:0] {
        OFF   = 3'd0,
        UP0   = 3'd1,
        DLY0  = 3'd2,
        UP1   = 3'd3,
        ON    = 3'd4,
        DN    = 3'd5,
        FAULT = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] SEQ_LAST = CNT_W'(SEQ_DLY - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(PG_TMO - 1);

    // ------------------------------------------------------------------
    // Two-flop synchronizers for every asynchronous input bit
    // ------------------------------------------------------------------
    logic [1:0] req_s1_reg, req_s2_reg;
    logic [1:0] pg_s1_reg, pg_s2_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    req_s1_reg[gi] <= 1'b0;
                    req_s2_reg[gi] <= 1'b0;
                    pg_s1_reg[gi]  <= 1'b0;
                    pg_s2_reg[gi]  <= 1'b0;
                end else begin
                    req_s1_reg[gi] <= req[gi];
                    req_s2_reg[gi] <= req_s1_reg[gi];
                    pg_s1_reg[gi]  <= pgood[gi];
                    pg_s2_reg[gi]  <= pg_s1_reg[gi];
                end
            end
        end
    endgenerate

    // Previous value of the synchronized fault-clear bit, for edge detection
    logic clr_prev_reg;
    logic clr_edge;
    logic on_req;

    assign clr_edge = req_s2_reg[1] & ~clr_prev_reg;
    assign on_req   = req_s2_reg[0];

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [1:0]       code_next;
    logic [1:0]       rail_en_next;
    logic             power_ok_next;
    logic             fault_next;

    function automatic logic is_counting(input state_t s);
        return (s == UP0) || (s == DLY0) || (s == UP1) || (s == DN);
    endfunction

    always_comb begin
        state_next = state_reg;
        code_next  = fault_code;
        case (state_reg)
            OFF: begin
                if (on_req) state_next = UP0;
            end
            UP0: begin
                if (!on_req)                    state_next = DN;
                else if (pg_s2_reg[0])          state_next = DLY0;
                else if (cnt_reg == TMO_LAST) begin
                    state_next = FAULT;
                    code_next  = 2'b01;
                end
            end
            DLY0: begin
                if (!on_req)                    state_next = DN;
                else if (!pg_s2_reg[0]) begin
                    state_next = FAULT;
                    code_next  = 2'b01;
                end
                else if (cnt_reg == SEQ_LAST)   state_next = UP1;
            end
            UP1: begin
                if (!on_req)                    state_next = DN;
                else if (!pg_s2_reg[0]) begin
                    state_next = FAULT;
                    code_next  = 2'b01;
                end
                else if (pg_s2_reg[1])          state_next = ON;
                else if (cnt_reg == TMO_LAST) begin
                    state_next = FAULT;
                    code_next  = 2'b10;
                end
            end
            ON: begin
                // Loss of power-good wins over a simultaneous request-off
                if (pg_s2_reg != 2'b11) begin
                    state_next = FAULT;
                    code_next  = 2'b11;
                end
                else if (!on_req)               state_next = DN;
            end
            DN: begin
                // A re-asserted request does not abort the power-down hold
                if (cnt_reg == SEQ_LAST)        state_next = OFF;
            end
            FAULT: begin
                if (clr_edge && !on_req) begin
                    state_next = OFF;
                    code_next  = 2'b00;
                end
            end
            default: begin
                state_next = OFF;
                code_next  = 2'b00;
            end
        endcase

        // Counter restarts on entry to a counting state and holds 0 elsewhere.
        // Every counting state leaves at or before its terminal count.
        if (is_counting(state_next) && (state_next == state_reg))
            cnt_next = cnt_reg + CNT_W'(1);
        else
            cnt_next = '0;

        // Outputs decode the next state so they become registered outputs
        case (state_next)
            UP0, DLY0, DN: rail_en_next = 2'b01;
            UP1, ON:       rail_en_next = 2'b11;
            default:       rail_en_next = 2'b00;
        endcase
        power_ok_next = (state_next == ON);
        fault_next    = (state_next == FAULT);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= OFF;
            cnt_reg      <= '0;
            clr_prev_reg <= 1'b0;
            rail_en      <= 2'b00;
            power_ok     <= 1'b0;
            fault        <= 1'b0;
            fault_code   <= 2'b00;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            clr_prev_reg <= req_s2_reg[1];
            rail_en      <= rail_en_next;
            power_ok     <= power_ok_next;
            fault        <= fault_next;
            fault_code   <= code_next;
        end
    end

endmodule

// File: tb/tb_power_rail_sequencer.sv
// -----------------------------------------------------------------------------
// tb_power_rail_sequencer
//
// Directed bench for power_rail_sequencer with SEQ_DLY=4, PG_TMO=16.
// Inputs change 1 ns after a rising edge. Outputs are checked at the same
// point. A synchronized input therefore shows on the outputs on the third
// following edge.
// -----------------------------------------------------------------------------
module tb_power_rail_sequencer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] req = 2'b00;
    logic [1:0] pgood = 2'b00;
    logic [1:0] rail_en;
    logic       power_ok;
    logic       fault;
    logic [1:0] fault_code;

    int checks = 0;
    int errors = 0;

    power_rail_sequencer #(
        .SEQ_DLY (4),
        .PG_TMO  (16),
        .CNT_W   (20)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req        (req),
        .pgood      (pgood),
        .rail_en    (rail_en),
        .power_ok   (power_ok),
        .fault      (fault),
        .fault_code (fault_code)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives a full power-up; ends on the first ON cycle (no checks here)
    task automatic power_up();
        req = 2'b01; pgood = 2'b00;
        tick(8);  pgood = 2'b01;
        tick(9);  pgood = 2'b11;
        tick(3);
    endtask

    // Fault clear: req low, then a clear edge with req[0]=0; ends in OFF
    task automatic clear_fault();
        req = 2'b00; pgood = 2'b00;
        tick(3);
        req = 2'b10;
        tick(3);
        req = 2'b00;
        tick(3);
    endtask

    task automatic test_reset();
        req = 2'b00; pgood = 2'b00; reset_n = 1'b0;
        tick(3);
        checks++;
        if ({rail_en, power_ok, fault, fault_code} !== 6'b0) begin
            errors++;
            $display("FAIL reset_state got=%b exp=%b", {rail_en, power_ok, fault, fault_code}, 6'b0);
        end
        reset_n = 1'b1;
        tick(4);
        checks++;
        if ({rail_en, power_ok, fault, fault_code} !== 6'b0) begin
            errors++;
            $display("FAIL idle_off got=%b exp=%b", {rail_en, power_ok, fault, fault_code}, 6'b0);
        end
        $display("test_reset done");
    endtask

    task automatic test_normal_up();
        req = 2'b01; pgood = 2'b00;
        tick(2);
        checks++;
        if (rail_en !== 2'b00) begin
            errors++; $display("FAIL up_latency2 rail_en=%b exp=00", rail_en);
        end
        tick(1);
        checks++;
        if (rail_en !== 2'b01) begin
            errors++; $display("FAIL up_rail0 rail_en=%b exp=01", rail_en);
        end
        tick(5); pgood = 2'b01;
        tick(6);
        checks++;
        if (rail_en !== 2'b01) begin
            errors++; $display("FAIL up_dly_hold rail_en=%b exp=01", rail_en);
        end
        tick(1);
        checks++;
        if (rail_en !== 2'b11) begin
            errors++; $display("FAIL up_rail1 rail_en=%b exp=11", rail_en);
        end
        tick(2); pgood = 2'b11;
        tick(2);
        checks++;
        if (power_ok !== 1'b0) begin
            errors++; $display("FAIL up_pok_early power_ok=%b exp=0", power_ok);
        end
        tick(1);
        checks++;
        if ({rail_en, power_ok, fault} !== 4'b1110) begin
            errors++; $display("FAIL up_on got=%b exp=1110", {rail_en, power_ok, fault});
        end
        $display("test_normal_up done");
    endtask

    task automatic test_power_down();
        req = 2'b00;
        tick(2);
        checks++;
        if ({rail_en, power_ok} !== 3'b111) begin
            errors++; $display("FAIL dn_latency got=%b exp=111", {rail_en, power_ok});
        end
        tick(1);
        checks++;
        if ({rail_en, power_ok} !== 3'b010) begin
            errors++; $display("FAIL dn_first got=%b exp=010", {rail_en, power_ok});
        end
        tick(3);
        checks++;
        if (rail_en !== 2'b01) begin
            errors++; $display("FAIL dn_hold rail_en=%b exp=01", rail_en);
        end
        tick(1);
        checks++;
        if (rail_en !== 2'b00) begin
            errors++; $display("FAIL dn_off rail_en=%b exp=00", rail_en);
        end
        pgood = 2'b00;
        tick(3);
        $display("test_power_down done");
    endtask

    task automatic test_rail1_timeout();
        req = 2'b01; pgood = 2'b00;
        tick(8); pgood = 2'b01;
        tick(7);
        checks++;
        if (rail_en !== 2'b11) begin
            errors++; $display("FAIL t1_up1 rail_en=%b exp=11", rail_en);
        end
        tick(15);
        checks++;
        if ({rail_en, fault} !== 3'b110) begin
            errors++; $display("FAIL t1_before got=%b exp=110", {rail_en, fault});
        end
        tick(1);
        checks++;
        if ({rail_en, fault, fault_code} !== 5'b00110) begin
            errors++; $display("FAIL t1_fault got=%b exp=00110", {rail_en, fault, fault_code});
        end
        req = 2'b00; pgood = 2'b00;
        tick(3);
        req = 2'b10;
        tick(2);
        checks++;
        if (fault !== 1'b1) begin
            errors++; $display("FAIL t1_clr_latency fault=%b exp=1", fault);
        end
        tick(1);
        checks++;
        if ({fault, fault_code} !== 3'b000) begin
            errors++; $display("FAIL t1_cleared got=%b exp=000", {fault, fault_code});
        end
        req = 2'b00;
        tick(3);
        $display("test_rail1_timeout done");
    endtask

    task automatic test_rail0_timeout();
        req = 2'b01; pgood = 2'b00;
        tick(18);
        checks++;
        if ({rail_en, fault} !== 3'b010) begin
            errors++; $display("FAIL t0_before got=%b exp=010", {rail_en, fault});
        end
        tick(1);
        checks++;
        if ({rail_en, fault, fault_code} !== 5'b00101) begin
            errors++; $display("FAIL t0_fault got=%b exp=00101", {rail_en, fault, fault_code});
        end
        clear_fault();
        checks++;
        if ({fault, fault_code} !== 3'b000) begin
            errors++; $display("FAIL t0_cleared got=%b exp=000", {fault, fault_code});
        end
        $display("test_rail0_timeout done");
    endtask

    task automatic test_brownout();
        power_up();
        pgood = 2'b10;
        tick(3);
        pgood = 2'b11;
        checks++;
        if ({rail_en, power_ok, fault, fault_code} !== 6'b000111) begin
            errors++; $display("FAIL bo_fault got=%b exp=000111", {rail_en, power_ok, fault, fault_code});
        end
        req = 2'b11;
        tick(5);
        checks++;
        if ({fault, fault_code} !== 3'b111) begin
            errors++; $display("FAIL bo_clr_ignored got=%b exp=111", {fault, fault_code});
        end
        req = 2'b00;
        tick(4);
        req = 2'b10;
        tick(2);
        checks++;
        if (fault !== 1'b1) begin
            errors++; $display("FAIL bo_clr_latency fault=%b exp=1", fault);
        end
        tick(1);
        checks++;
        if ({rail_en, fault, fault_code} !== 5'b00000) begin
            errors++; $display("FAIL bo_cleared got=%b exp=00000", {rail_en, fault, fault_code});
        end
        req = 2'b00; pgood = 2'b00;
        tick(3);
        $display("test_brownout done");
    endtask

    task automatic test_simultaneous();
        power_up();
        req = 2'b00; pgood = 2'b01;
        tick(3);
        checks++;
        if ({rail_en, power_ok, fault, fault_code} !== 6'b000111) begin
            errors++; $display("FAIL sim_fault_wins got=%b exp=000111", {rail_en, power_ok, fault, fault_code});
        end
        clear_fault();
        checks++;
        if ({fault, fault_code} !== 3'b000) begin
            errors++; $display("FAIL sim_cleared got=%b exp=000", {fault, fault_code});
        end
        $display("test_simultaneous done");
    endtask

    task automatic test_reset_in_up1();
        req = 2'b01; pgood = 2'b00;
        tick(8); pgood = 2'b01;
        tick(7);
        checks++;
        if (rail_en !== 2'b11) begin
            errors++; $display("FAIL rst_up1 rail_en=%b exp=11", rail_en);
        end
        tick(2);
        reset_n = 1'b0; pgood = 2'b00;
        #2;
        checks++;
        if ({rail_en, power_ok, fault} !== 4'b0000) begin
            errors++; $display("FAIL rst_async got=%b exp=0000", {rail_en, power_ok, fault});
        end
        tick(2);
        reset_n = 1'b1;
        tick(2);
        checks++;
        if (rail_en !== 2'b00) begin
            errors++; $display("FAIL rst_release_sync rail_en=%b exp=00", rail_en);
        end
        tick(1);
        checks++;
        if (rail_en !== 2'b01) begin
            errors++; $display("FAIL rst_restart rail_en=%b exp=01", rail_en);
        end
        req = 2'b00;
        tick(10);
        $display("test_reset_in_up1 done");
    endtask

    initial begin
        test_reset();
        test_normal_up();
        test_power_down();
        test_rail1_timeout();
        test_rail0_timeout();
        test_brownout();
        test_simultaneous();
        test_reset_in_up1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
